reorder_buffer: RTL

Circular reorder buffer that allocates ROB tags at decode, collects writeback results, and retires instructions in program order. It is the commit-side partner of the register map table. It produces the map table's commit read address and its one-hot per-register clear vector, so a register's mapping returns to tag 0 ("value in register file") when its youngest producer commits. Tags are 1..ROBsize; entry index i carries tag i+1.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_ptr.sv | 31 +++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer slice.
package rob_pkg;

    localparam int         ARCH_REGS = 32;
    localparam logic [4:0] ZERO_REG  = 5'd31;

    // One ROB slot: lifecycle flags, destination and result.
    typedef struct packed {
        logic        valid;
        logic        done;
        logic        regWrite;
        logic [4:0]  dest;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around index counter used for the ROB head and tail pointers.
// DEPTH need not be a power of two; wrap is an explicit compare.
module rob_ptr #(
    parameter int DEPTH = 32,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] idx_q, idx_d;

    // Next index: advance on enable, wrapping DEPTH-1 back to 0.
    always_comb begin
        idx_d = idx_q;
        if (inc_i) begin
            idx_d = (idx_q == W'(DEPTH - 1)) ? '0 : idx_q + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at decode, collects writebacks,
// retires in program order and drives the map table commit-side clear.
// Entry index i carries tag i+1; tag 0 means "value in register file".
// Optional feature macro: ROB_FORWARD_EN adds two operand read ports that
// return completed (or same-cycle written back) values by tag.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROBsize      = 32,
    parameter int mapValueSize = $clog2(ROBsize + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_valid_i,
    input  logic                    alloc_regWrite_i,
    input  logic [4:0]              alloc_dest_i,
    output logic                    alloc_ready_o,
    output logic [mapValueSize-1:0] alloc_tag_o,
    input  logic                    wb_valid_i,
    input  logic [mapValueSize-1:0] wb_tag_i,
    input  logic [31:0]             wb_value_i,
    output logic                    commit_valid_o,
    output logic                    commit_regWrite_o,
    output logic [4:0]              commit_dest_o,
    output logic [31:0]             commit_value_o,
    input  logic [mapValueSize-1:0] mapCommitData_i,
    output logic [31:0]             resets_o
`ifdef ROB_FORWARD_EN
    ,
    input  logic [mapValueSize-1:0] readTag1_i,
    input  logic [mapValueSize-1:0] readTag2_i,
    output logic [31:0]             readData1_o,
    output logic [31:0]             readData2_o,
    output logic                    readReady1_o,
    output logic                    readReady2_o
`endif
);

    localparam int IW = $clog2(ROBsize);
    localparam int CW = $clog2(ROBsize + 1);

    rob_entry_t              entries_q [ROBsize];
    rob_entry_t              entries_d [ROBsize];
    logic [CW-1:0]           count_q, count_d;
    logic [IW-1:0]           head, tail;
    rob_entry_t              head_e;
    logic [mapValueSize-1:0] head_tag;
    logic                    alloc_fire, commit_fire, wb_hit;

    function automatic logic tag_ok(input logic [mapValueSize-1:0] tag);
        return (tag != '0) && (int'(tag) <= ROBsize);
    endfunction

    function automatic logic [IW-1:0] tag_idx(input logic [mapValueSize-1:0] tag);
        return IW'(tag - mapValueSize'(1));
    endfunction

    assign head_e      = entries_q[head];
    assign head_tag    = mapValueSize'(head) + mapValueSize'(1);
    assign alloc_ready_o = (count_q != CW'(ROBsize));
    assign alloc_tag_o = mapValueSize'(tail) + mapValueSize'(1);
    assign alloc_fire  = alloc_valid_i & alloc_ready_o;
    assign commit_fire = head_e.valid & head_e.done;
    assign wb_hit      = wb_valid_i & tag_ok(wb_tag_i) & entries_q[tag_idx(wb_tag_i)].valid;

    rob_ptr #(.DEPTH(ROBsize), .W(IW)) u_head (
        .clk(clk), .reset(reset), .inc_i(commit_fire), .idx_o(head)
    );
    rob_ptr #(.DEPTH(ROBsize), .W(IW)) u_tail (
        .clk(clk), .reset(reset), .inc_i(alloc_fire), .idx_o(tail)
    );

    // Next entry state. Writeback is applied before the commit clear so a
    // stray writeback to the retiring slot cannot resurrect it.
    always_comb begin
        for (int i = 0; i < ROBsize; i++) entries_d[i] = entries_q[i];
        if (wb_hit) begin
            entries_d[tag_idx(wb_tag_i)].done  = 1'b1;
            entries_d[tag_idx(wb_tag_i)].value = wb_value_i;
        end
        if (commit_fire) entries_d[head] = '0;
        if (alloc_fire) begin
            entries_d[tail].valid    = 1'b1;
            entries_d[tail].done     = 1'b0;
            entries_d[tail].regWrite = alloc_regWrite_i;
            entries_d[tail].dest     = alloc_dest_i;
            entries_d[tail].value    = '0;
        end
    end

    // Occupancy: a simultaneous alloc and commit leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry array and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROBsize; i++) entries_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < ROBsize; i++) entries_q[i] <= entries_d[i];
            count_q <= count_d;
        end
    end

    assign commit_valid_o    = commit_fire;
    assign commit_regWrite_o = commit_fire & head_e.regWrite & (head_e.dest != ZERO_REG);
    assign commit_dest_o     = head_e.dest;
    assign commit_value_o    = head_e.value;

    // Clear the map entry only if this commit is still the youngest producer.
    always_comb begin
        resets_o = '0;
        if (commit_regWrite_o && (mapCommitData_i == head_tag)) begin
            resets_o[head_e.dest] = 1'b1;
        end
    end

`ifdef ROB_FORWARD_EN
    logic [1:0][mapValueSize-1:0] rtag;
    logic [1:0][31:0]             rdata;
    logic [1:0]                   rready;

    assign rtag = {readTag2_i, readTag1_i};

    // Operand lookup: stored completed value, else same-cycle writeback bypass.
    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int p = 0; p < 2; p++) begin
            if (tag_ok(rtag[p]) && entries_q[tag_idx(rtag[p])].valid) begin
                if (entries_q[tag_idx(rtag[p])].done) begin
                    rready[p] = 1'b1;
                    rdata[p]  = entries_q[tag_idx(rtag[p])].value;
                end else if (wb_valid_i && (wb_tag_i == rtag[p])) begin
                    rready[p] = 1'b1;
                    rdata[p]  = wb_value_i;
                end
            end
        end
    end

    assign readData1_o  = rdata[0];
    assign readData2_o  = rdata[1];
    assign readReady1_o = rready[0];
    assign readReady2_o = rready[1];
`endif

endmodule
